store_buffer: RTL

- Write buffer between the execute stage's memory request and the word-addressed, single-port data memory.
- Stores are queued in a small FIFO and written back to memory only in cycles when no load needs the memory port, so loads never wait behind stores.
- Loads are checked against every queued store; the youngest match is returned without a memory access.
- A flush request drains the buffer completely before halt or an I/O fence.

---
 rtl/store_buffer_pkg.sv | 13 +
 rtl/store_buffer_stb_match.sv | 31 +++
 rtl/store_buffer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared widths and depth defaults for the store buffer
package store_buffer_pkg;

   localparam int ADDR_LEN_DEF = 32;
   localparam int DATA_LEN_DEF = 32;
   localparam int STB_DEPTH    = 4;

   // Word address carried by a buffer entry (byte offset bits dropped)
   function automatic int word_addr_len(input int addr_len);
      return addr_len - 2;
   endfunction

endpackage

// File: rtl/store_buffer_stb_match.sv
// rtl/store_buffer_stb_match.sv - youngest-match search over queued store entries
module stb_match #(
   parameter int DEPTH  = 4,
   parameter int WA_LEN = 30,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]             i_valid,
   input  logic [DEPTH-1:0][WA_LEN-1:0] i_addr,
   input  logic [PW-1:0]                i_head,
   input  logic [WA_LEN-1:0]            i_query,
   output logic                         o_hit,
   output logic [PW-1:0]                o_index
);

   logic [PW-1:0] w_idx;

   // Walk entries oldest to youngest starting at head; the last match wins
   always_comb begin
      o_hit   = 1'b0;
      o_index = '0;
      w_idx   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = i_head + PW'(k);
         if (i_valid[w_idx] && (i_addr[w_idx] == i_query)) begin
            o_hit   = 1'b1;
            o_index = w_idx;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store FIFO that drains to memory whenever loads leave the port idle
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int ADDR_LEN = ADDR_LEN_DEF,
   parameter int DATA_LEN = DATA_LEN_DEF,
   parameter int DEPTH    = STB_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_read,
   input  logic                       req_write,
   input  logic [ADDR_LEN-1:0]        req_addr,
   input  logic [DATA_LEN-1:0]        req_wdata,
   output logic [DATA_LEN-1:0]        core_rdata,
   input  logic                       flush_req,
   output logic                       stall,
   output logic                       buf_empty,
   output logic [$clog2(DEPTH):0]     buf_count,
   output logic                       mem_read_flag,
   output logic                       mem_write_flag,
   output logic [ADDR_LEN-1:0]        mem_addr,
   output logic [DATA_LEN-1:0]        mem_write_data,
   input  logic [DATA_LEN-1:0]        mem_read_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int WA = word_addr_len(ADDR_LEN);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0][WA-1:0]       r_addr;
   logic [DEPTH-1:0][DATA_LEN-1:0] r_data;
   logic [DEPTH-1:0]               r_valid;
   logic [PW-1:0]                  r_head;
   logic [PW-1:0]                  r_tail;
   logic [CW-1:0]                  r_count;

   logic          w_empty;
   logic          w_stall;
   logic          w_rd;
   logic          w_wr;
   logic          w_hit;
   logic [PW-1:0] w_hit_idx;
   logic          w_miss;
   logic          w_drain;
   logic          w_unused;

   assign w_unused = &{1'b0, req_addr[1:0]};

   stb_match #(
      .DEPTH  (DEPTH),
      .WA_LEN (WA)
   ) u_match (
      .i_valid (r_valid),
      .i_addr  (r_addr),
      .i_head  (r_head),
      .i_query (req_addr[ADDR_LEN-1:2]),
      .o_hit   (w_hit),
      .o_index (w_hit_idx)
   );

   // Request qualification: a simultaneous read+write is a write; a stall masks both.
   // Draining is suppressed in the reset cycle so nothing is committed across reset.
   always_comb begin
      w_empty = (r_count == '0);
      w_stall = flush_req & ~w_empty;
      w_rd    = req_read & ~req_write & ~w_stall;
      w_wr    = req_write & ~w_stall;
      w_miss  = w_rd & ~w_hit;
      w_drain = ~w_empty & ~w_miss & ~rst;
   end

   // Memory port and core-facing outputs; a load miss owns the port, otherwise the head drains
   always_comb begin
      stall          = w_stall;
      buf_empty      = w_empty;
      buf_count      = r_count;
      mem_read_flag  = w_miss;
      mem_write_flag = w_drain;
      mem_addr       = '0;
      mem_write_data = '0;
      core_rdata     = '0;
      if (w_miss) begin
         mem_addr = req_addr;
      end else if (w_drain) begin
         mem_addr       = {r_addr[r_head], 2'b00};
         mem_write_data = r_data[r_head];
      end
      if (w_rd) begin
         core_rdata = w_hit ? r_data[w_hit_idx] : mem_read_data;
      end
   end

   // FIFO state: dequeue at head on drain, enqueue at tail on store, occupancy tracks the net change
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
      end else begin
         if (w_drain) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + PW'(1);
         end
         if (w_wr) begin
            r_valid[r_tail] <= 1'b1;
            r_addr[r_tail]  <= req_addr[ADDR_LEN-1:2];
            r_data[r_tail]  <= req_wdata;
            r_tail          <= r_tail + PW'(1);
         end
         case ({w_wr, w_drain})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
